// File: rtl/lcd_timing_gen.sv
// Raster timing for a 480x272 LCD: startup delay, h/v counters,
// and HSYNC/VSYNC/DE registered one clock behind the counters.
module lcd_timing_gen #(
    parameter int unsigned H_SYNC         = 41,
    parameter int unsigned H_BACK         = 2,
    parameter int unsigned H_ACTIVE       = 480,
    parameter int unsigned H_FRONT        = 2,
    parameter int unsigned V_SYNC         = 10,
    parameter int unsigned V_BACK         = 2,
    parameter int unsigned V_ACTIVE       = 272,
    parameter int unsigned V_FRONT        = 2,
    parameter int unsigned STARTUP_CYCLES = 9000
) (
    input  logic       clk9MHz,
    input  logic       reset,
    output logic [9:0] vgaCount,
    output logic [8:0] lineCount,
    output logic       inActive,
    output logic       frameStart,
    output logic       start,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       dataEnable
);
    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int TW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
    localparam logic [8:0] V_SYNC_W = 9'(V_SYNC);
    localparam logic [9:0] HA_FIRST = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] HA_LAST = 10'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [8:0] VA_FIRST = 9'(V_SYNC + V_BACK);
    localparam logic [8:0] VA_LAST = 9'(V_SYNC + V_BACK + V_ACTIVE - 1);
    localparam logic [TW-1:0] T_LAST = TW'(STARTUP_CYCLES - 1);

    if (H_TOTAL > 1024) begin : g_h_chk
        $error("H_TOTAL exceeds 10-bit counter");
    end
    if (V_TOTAL > 512) begin : g_v_chk
        $error("V_TOTAL exceeds 9-bit counter");
    end
    if (STARTUP_CYCLES < 1) begin : g_s_chk
        $error("STARTUP_CYCLES must be at least 1");
    end

    typedef enum logic {
        WAIT,
        RUN
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [9:0]    h_q, h_d;
    logic [8:0]    v_q, v_d;
    logic          hs_n_q, vs_n_q, de_q;
    logic          run;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        h_d     = h_q;
        v_d     = v_q;
        unique case (state_q)
            WAIT: begin
                timer_d = timer_q + TW'(1);
                if (timer_q == T_LAST) state_d = RUN;
            end
            RUN: begin
                if (h_q == H_LAST) begin
                    h_d = '0;
                    v_d = (v_q == V_LAST) ? '0 : v_q + 9'd1;
                end else begin
                    h_d = h_q + 10'd1;
                end
            end
            default: state_d = WAIT;
        endcase
    end

    assign run = (state_q == RUN);
    assign inActive = run &&
                      h_q >= HA_FIRST && h_q <= HA_LAST &&
                      v_q >= VA_FIRST && v_q <= VA_LAST;
    assign frameStart = run && h_q == '0 && v_q == '0;

    always_ff @(posedge clk9MHz) begin
        if (reset) begin
            state_q <= WAIT;
            timer_q <= '0;
            h_q     <= '0;
            v_q     <= '0;
            hs_n_q  <= 1'b1;
            vs_n_q  <= 1'b1;
            de_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            h_q     <= h_d;
            v_q     <= v_d;
            // panel signals lag the counters to line up with registered RGB
            hs_n_q  <= ~(run && h_q < H_SYNC_W);
            vs_n_q  <= ~(run && v_q < V_SYNC_W);
            de_q    <= inActive;
        end
    end

    assign vgaCount   = h_q;
    assign lineCount  = v_q;
    assign start      = run;
    assign hsync_n    = hs_n_q;
    assign vsync_n    = vs_n_q;
    assign dataEnable = de_q;
endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: time-since-reset reference model checked every
// cycle, plus literal line/frame measurements and randomized resets.
module tb_lcd_timing_gen;
    localparam int HS = 41, HB = 2, HA = 480, HF = 2;
    localparam int VS = 3, VB = 2, VA = 4, VF = 2;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int S = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] vgaCount;
    logic [8:0] lineCount;
    logic       inActive, frameStart, start;
    logic       hsync_n, vsync_n, dataEnable;

    lcd_timing_gen #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
        .STARTUP_CYCLES(S)
    ) dut (
        .clk9MHz(clk), .reset(rst),
        .vgaCount(vgaCount), .lineCount(lineCount),
        .inActive(inActive), .frameStart(frameStart), .start(start),
        .hsync_n(hsync_n), .vsync_n(vsync_n), .dataEnable(dataEnable)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors = 0;
    int n = 0;
    int cyc = 0;
    bit e_hs = 1, e_vs = 1, e_de = 0;

    int hl = 0, dl = 0, vl = 0, decnt = 0;
    int last0 = -1, lastfs = -1;
    int pv = 0, pl = 0;
    bit pst = 0, phs = 1, pde = 0;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // n = clocks since the last edge that sampled reset high
    function automatic void model(input int t, output bit run,
                                  output int v, output int l,
                                  output bit act, output bit fs);
        int p;
        run = (t >= S);
        p = run ? t - S : 0;
        v = run ? p % HT : 0;
        l = run ? (p / HT) % VT : 0;
        act = run && v >= HS + HB && v < HS + HB + HA &&
              l >= VS + VB && l < VS + VB + VA;
        fs = run && (p % (HT * VT)) == 0;
    endfunction

    task automatic tick(input logic r);
        bit run, act, fs;
        int v, l;
        model(n, run, v, l, act, fs);
        e_hs = r ? 1'b1 : !(run && v < HS);
        e_vs = r ? 1'b1 : !(run && l < VS);
        e_de = r ? 1'b0 : act;
        rst = r;
        @(posedge clk);
        n = r ? 0 : n + 1;
        cyc++;
        @(negedge clk);
        model(n, run, v, l, act, fs);
        chk("start", int'(start), int'(run));
        chk("vgaCount", int'(vgaCount), v);
        chk("lineCount", int'(lineCount), l);
        chk("inActive", int'(inActive), int'(act));
        chk("frameStart", int'(frameStart), int'(fs));
        chk("hsync_n", int'(hsync_n), int'(e_hs));
        chk("vsync_n", int'(vsync_n), int'(e_vs));
        chk("dataEnable", int'(dataEnable), int'(e_de));

        if (r) begin
            hl = 0; dl = 0; vl = 0; decnt = 0;
            last0 = -1; lastfs = -1;
        end
        if (!hsync_n && phs) chk("hs_fall_vga", pv, 0);
        if (!hsync_n) hl++;
        else if (hl > 0) begin
            chk("hs_low_len", hl, 41); hl = 0;
        end
        if (dataEnable && !pde) chk("de_rise_vga", pv, 43);
        if (dataEnable) dl++;
        else if (dl > 0) begin
            chk("de_run_len", dl, 480); dl = 0;
        end
        if (!vsync_n) vl++;
        else if (vl > 0) begin
            chk("vs_low_len", vl, 3 * 525); vl = 0;
        end
        if (start && vgaCount == 0) begin
            if (last0 >= 0) chk("line_period", cyc - last0, 525);
            last0 = cyc;
        end
        if (frameStart) begin
            if (lastfs >= 0) begin
                chk("frame_period", cyc - lastfs, 525 * 11);
                chk("de_per_frame", decnt, 480 * 4);
            end
            lastfs = cyc; decnt = 0;
        end
        if (dataEnable) decnt++;
        if (pst && start && pv == HT - 1 && pl == VT - 1) begin
            chk("wrap_vga", int'(vgaCount), 0);
            chk("wrap_line", int'(lineCount), 0);
            chk("wrap_fs", int'(frameStart), 1);
        end
        if (start && (lineCount < 5 || lineCount > 8))
            chk("blank_de", int'(inActive | dataEnable), 0);
        pv = vgaCount; pl = lineCount;
        pst = start; phs = hsync_n; pde = dataEnable;
    endtask

    task automatic check_startup;
        for (int i = 0; i < S; i++) begin
            chk("wait_start", int'(start), 0);
            chk("wait_cnt", int'(vgaCount) + int'(lineCount), 0);
            tick(1'b0);
        end
        chk("run_start", int'(start), 1);
        chk("run_fs", int'(frameStart), 1);
    endtask

    initial begin
        int guard;
        int k;
        bit r;
        @(negedge clk);
        tick(1'b1);
        tick(1'b1);
        chk("rst_hs", int'(hsync_n), 1);
        chk("rst_de", int'(dataEnable), 0);
        check_startup();

        repeat (13000) tick(1'b0);

        guard = 0;
        while (!(vgaCount == 300 && lineCount == 5) && guard < 7000) begin
            tick(1'b0);
            guard++;
        end
        chk("seek_300_5", int'(guard < 7000), 1);
        tick(1'b1);
        chk("mid_vga", int'(vgaCount), 0);
        chk("mid_line", int'(lineCount), 0);
        chk("mid_hs", int'(hsync_n), 1);
        chk("mid_vs", int'(vsync_n), 1);
        chk("mid_de", int'(dataEnable), 0);
        chk("mid_start", int'(start), 0);
        check_startup();

        for (int i = 0; i < 30000; i++) begin
            r = ($urandom_range(0, 1999) == 0) ||
                (n < S && $urandom_range(0, 49) == 0);
            if (r) begin
                k = $urandom_range(1, 3);
                repeat (k) tick(1'b1);
            end else begin
                tick(1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end
endmodule
